// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
//
// Purpose:
//   Multi-cycle controller that forms the low WIDTH bits of op_a * op_b
//   (RV32 MUL semantics). It does not have its own adder or shifter. Instead it
//   borrows the shared integer ALU and runs a shift-and-add loop:
//     ADD state : acc + M        (ALU opcode 4'b0000); the sum is kept when Q[0]=1
//     SHL state : M << 1         (ALU opcode 4'b0101); Q shifts right by one
//   While busy, the sequencer owns the ALU operand muxes. The core stalls on
//   busy and takes the product when done pulses.
//
// Parameters:
//   WIDTH       operand/result width. It must match the ALU datapath width.
//   EARLY_EXIT  1: finish as soon as the remaining multiplier bits are all zero.
//               0: always run WIDTH iterations.
//
// Ports:
//   clk          in   1      clock; all state changes on the rising edge
//   rst          in   1      synchronous reset, active-high; wins over start
//   start        in   1      request; sampled only in IDLE
//   op_a         in   WIDTH  multiplicand; latched when start is accepted
//   op_b         in   WIDTH  multiplier; latched when start is accepted
//   busy         out  1      high whenever the FSM is not in IDLE
//   done         out  1      one-cycle pulse; product is valid in this cycle
//   product      out  WIDTH  registered (a*b) mod 2^WIDTH; holds until next done
//   alu_a        out  WIDTH  ALU operand A
//   alu_b        out  WIDTH  ALU operand B
//   alu_control  out  4      ALU opcode (ADD while idle)
//   alu_result   in   WIDTH  combinational ALU result for the current operands
// -----------------------------------------------------------------------------
module alu_mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_SHL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b0101;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;   // running partial product
    logic [WIDTH-1:0] m;     // multiplicand, shifted left once per iteration
    logic [WIDTH-1:0] q;     // multiplier, shifted right once per iteration
    logic [CNT_W-1:0] cnt;   // completed iterations

    logic [WIDTH-1:0] q_next;
    logic             last_iter;

    assign q_next = q >> 1;

    // Stop after the WIDTH-th iteration. With early exit, also stop when no set
    // multiplier bits remain, because every later ADD would leave acc unchanged.
    assign last_iter = (cnt == CNT_LAST) || (EARLY_EXIT && (q_next == '0));

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: use non-blocking assignments in clocked blocks. Every register then
    // updates from the values sampled at the same edge. For example, q and cnt
    // in SHL both use the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            m       <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        m     <= op_a;
                        q     <= op_b;
                        cnt   <= '0;
                        state <= S_ADD;
                    end
                end

                S_ADD: begin
                    // The ALU computes acc + M every ADD cycle. The sum is kept
                    // only when the current multiplier bit is set.
                    if (q[0]) begin
                        acc <= alu_result;
                    end
                    state <= S_SHL;
                end

                S_SHL: begin
                    m   <= alu_result;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        // acc is already final: SHL never changes it. Capturing
                        // it here makes product valid in the same cycle as done.
                        product <= acc;
                        state   <= S_DONE;
                    end else begin
                        state <= S_ADD;
                    end
                end

                S_DONE: begin
                    // start is ignored here. The earliest new request is taken
                    // in the first IDLE cycle after this one.
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Status and ALU operand drive
    // -------------------------------------------------------------------------
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // NOTE: assign every output at the top of the block before the case. A path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        case (state)
            S_ADD: begin
                alu_a       = acc;
                alu_b       = m;
                alu_control = ALU_ADD;
            end
            S_SHL: begin
                alu_a       = m;
                alu_b       = WIDTH'(1);
                alu_control = ALU_SLL;
            end
            default: begin
                // IDLE and DONE: the ALU is handed back with zero operands / ADD.
                alu_a       = '0;
                alu_b       = '0;
                alu_control = ALU_ADD;
            end
        endcase
    end

endmodule
